inv_mix_columns_seq: RTL

Iterative AES InvMixColumns engine for the decryption datapath. It takes a full 128-bit AES state over a valid/ready handshake and processes COLS_PER_CYCLE columns per clock. It returns the transformed state over a second valid/ready handshake. It sits between InvShiftRows/InvSubBytes/AddRoundKey in the decryption round and is the counterpart of the combinational forward mix_column used on the encrypt side.

---
 rtl/aes_pkg.sv | 10 +
 rtl/inv_mix_column.sv | 20 ++
 rtl/inv_mix_columns_seq.sv | 74 +++++++
 3 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types, GF(2^8) doubling helper and InvMixColumns FSM states
package aes_pkg;
    localparam logic [7:0] AES_POLY = 8'h1B;
    typedef logic [31:0] word_t;
    typedef logic [127:0] state_t;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} imc_state_e;
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction
endpackage

// File: rtl/inv_mix_column.sv
// inv_mix_column: combinational InvMixColumns on one 32-bit column (row0 in the MSB byte)
module inv_mix_column
    import aes_pkg::*;
(
    input  word_t col,
    output word_t res
);
    logic [7:0] a0, a1, a2, a3, u, v, p0, p1, p2, p3, t;
    assign {a0, a1, a2, a3} = col;
    // Pre-scale by 4 on opposite byte pairs, then reuse the forward MixColumns network
    assign u  = xtime(xtime(a0 ^ a2));
    assign v  = xtime(xtime(a1 ^ a3));
    assign p0 = a0 ^ u;
    assign p1 = a1 ^ v;
    assign p2 = a2 ^ u;
    assign p3 = a3 ^ v;
    assign t  = p0 ^ p1 ^ p2 ^ p3;
    assign res = {p0 ^ t ^ xtime(p0 ^ p1), p1 ^ t ^ xtime(p1 ^ p2),
                  p2 ^ t ^ xtime(p2 ^ p3), p3 ^ t ^ xtime(p3 ^ p0)};
endmodule

// File: rtl/inv_mix_columns_seq.sv
// inv_mix_columns_seq: iterative InvMixColumns over a 128-bit state, COLS_PER_CYCLE columns per clock
module inv_mix_columns_seq
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);
    localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("COLS_PER_CYCLE must be 1, 2 or 4");
    end

    imc_state_e st, st_n;
    logic [1:0] cnt;
    state_t data_q;
    word_t [3:0] cur, nxt;
    logic [1:0] idx [COLS_PER_CYCLE];
    word_t col_res [COLS_PER_CYCLE];

    // Column 0 sits in the top word, so column c is cur[3-c]
    assign cur = data_q;

    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
        assign idx[g] = cnt + 2'(g);
        inv_mix_column u_col (
            .col(cur[2'd3 - idx[g]]),
            .res(col_res[g])
        );
    end

    always_comb begin
        nxt = cur;
        for (int i = 0; i < COLS_PER_CYCLE; i++) nxt[2'd3 - idx[i]] = col_res[i];
    end

    always_comb begin
        in_ready  = st == IDLE;
        out_valid = st == DONE;
        busy      = st == BUSY;
        st_n = (st == IDLE && in_valid)  ? BUSY :
               (st == BUSY && cnt == LAST) ? DONE :
               (st == DONE && out_ready) ? IDLE : st;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st     <= IDLE;
            cnt    <= '0;
            data_q <= '0;
        end else begin
            st <= st_n;
            if (st == IDLE && in_valid) begin
                data_q <= in_data;
                cnt    <= '0;
            end else if (st == BUSY) begin
                data_q <= nxt;
                cnt    <= cnt + STEP;
            end
        end
    end

    assign out_data = data_q;
endmodule
